fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit single-issue core. Sits directly upstream of the combinational instruction memory and between it and the decoder.
- Owns the program counter and drives the memory address. Captures the returned instruction word into an instruction register and hands it to decode over a valid/ready handshake.
- Resolves absolute jumps (J) locally with no bubble. Accepts branch redirects from execute. Supports halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- J_OPCODE, 6'b000010, value of com[15:10] identifying J; target field is com[9:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  16  instruction memory address; equals pc register, combinational from it.
- imem_com  in  16  instruction word; valid in the same cycle as imem_addr (zero-latency memory).
- redirect_valid  in  1  execute-stage redirect (taken BEQ); single-cycle pulse.
- redirect_pc  in  16  redirect target.
- halt_req  in  1  level; fetch stops while high.
- dec_valid  out  1  instruction register holds a valid instruction.
- dec_ready  in  1  decoder accepts dec_com this cycle.
- dec_com  out  16  instruction register.
- dec_pc  out  16  address of dec_com.
- dec_pc_plus1  out  16  dec_pc+1, registered; used by BEQ target calculation.
- halted  out  1  high in HALT state with dec_valid low.
- fetch_count  out  16  count of instructions loaded into the IR.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; dec_valid=0; dec_com, dec_pc, dec_pc_plus1, fetch_count=0; halted=0; state=BOOT.
  - Reset mid-operation discards the IR and any pending redirect.
- States:
  - BOOT: first clock after reset release; no fetch; go to RUN (or HALT if halt_req=1).
  - RUN: normal fetch.
  - HALT: entered when halt_req=1 in RUN; return to RUN on the clock after halt_req=0. PC is unchanged across HALT.
- load = state==RUN && !halt_req && !redirect_valid && (!dec_valid || dec_ready).
- On load:
  - dec_com<=imem_com, dec_pc<=pc, dec_pc_plus1<=pc+1, dec_valid<=1.
  - fetch_count<=fetch_count+1, wrapping FFFF->0000.
- Next-PC priority (any state except BOOT):
  1. redirect_valid: pc<=redirect_pc; dec_valid<=0 (flush, even if dec_ready=0 or halted). Exactly one bubble.
  2. load with imem_com[15:10]==J_OPCODE: pc<={pc_plus1[15:10], imem_com[9:0]}. The J itself is still passed to decode; no bubble.
  3. load: pc<=pc+1, wrapping FFFF->0000.
  4. otherwise: pc holds.
- If dec_valid && dec_ready && !load (stall source is halt or BOOT), dec_valid<=0.
- If dec_valid && !dec_ready, IR and pc hold; dec_com is stable while dec_valid=1.
- Throughput: one instruction per clock when dec_ready=1 continuously. First dec_valid=1 appears 2 clocks after rst_n rises (BOOT, then load).
- HALT: in-flight IR stays valid until accepted; halted=1 once dec_valid=0. A redirect during HALT updates pc, and the state stays HALT.
- halted is registered and derived from next state/next dec_valid.
- All arithmetic is 16-bit unsigned modulo 2^16.

Test Plan:
1. Reset then dec_ready=1, memory holding sequential non-jump words at 0..3 -> dec_valid rises 2nd clock after release; dec_pc sequence 0,1,2,3 on consecutive clocks; fetch_count=4.
2. J at address 8 with target 10'd5 (pc_plus1[15:10]=0) -> dec_pc sequence 7,8,5,6 with no bubble; dec_com at dec_pc 8 is the J word.
3. redirect_valid pulse with redirect_pc=16'h0007 while dec_pc=5 valid and dec_ready=0 -> next clock dec_valid=0, pc=7; following clock dec_pc=7 valid.
4. dec_ready held 0 for 3 clocks at dec_pc=2 -> dec_com, dec_pc, imem_addr=3 stable; fetch_count unchanged; dec_ready=1 resumes with dec_pc=3.
5. halt_req=1 while dec_pc=4 valid, dec_ready=1 -> IR drains; halted=1; pc=5 held; fetch_count frozen. Release -> dec_pc=5 after one clock in RUN.
6. pc=FFFF fetch -> next dec_pc=0000. Assert rst_n=0 mid-stall -> all outputs zero immediately (async), pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the zero-latency instruction memory,
// and holds one fetched instruction in the IR for the decoder.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [5:0]  J_OPCODE = 6'b000010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_com,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        halt_req,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_com,
  output logic [15:0] dec_pc,
  output logic [15:0] dec_pc_plus1,
  output logic        halted,
  output logic [15:0] fetch_count
);

  // Decoder handshake: an IR transfer happens on a clock where dec_valid && dec_ready;
  // dec_com/dec_pc/dec_pc_plus1 stay stable while dec_valid is high and dec_ready is low.
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, pc_plus1;
  logic        load, is_jump, dec_valid_nxt;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 16'd1;
  assign is_jump   = (imem_com[15:10] == J_OPCODE);
  assign load      = (state == RUN) && !halt_req && !redirect_valid && (!dec_valid || dec_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = halt_req ? HALT : RUN;
      RUN:     state_nxt = halt_req ? HALT : RUN;
      HALT:    state_nxt = halt_req ? HALT : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Redirect wins over everything; J resolves in-place so decode sees no bubble.
  always_comb begin
    pc_nxt = pc;
    if (state != BOOT) begin
      if (redirect_valid)
        pc_nxt = redirect_pc;
      else if (load && is_jump)
        pc_nxt = {pc_plus1[15:10], imem_com[9:0]};
      else if (load)
        pc_nxt = pc_plus1;
    end
  end

  always_comb begin
    dec_valid_nxt = dec_valid;
    if (redirect_valid)
      dec_valid_nxt = 1'b0;
    else if (load)
      dec_valid_nxt = 1'b1;
    else if (dec_valid && dec_ready)
      dec_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      dec_valid    <= 1'b0;
      dec_com      <= 16'h0000;
      dec_pc       <= 16'h0000;
      dec_pc_plus1 <= 16'h0000;
      fetch_count  <= 16'h0000;
      halted       <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      dec_valid <= dec_valid_nxt;
      halted    <= (state_nxt == HALT) && !dec_valid_nxt;
      if (load) begin
        dec_com      <= imem_com;
        dec_pc       <= pc;
        dec_pc_plus1 <= pc_plus1;
        fetch_count  <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory, scripted scenarios and a
// scoreboard of expected {dec_pc, dec_com} transfers.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_com;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_com;
  logic [15:0] dec_pc;
  logic [15:0] dec_pc_plus1;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [0:65535];
  logic [31:0] exp_q[$];
  int          checks;
  int          failures;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_com       (imem_com),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_com        (dec_com),
    .dec_pc         (dec_pc),
    .dec_pc_plus1   (dec_pc_plus1),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  assign imem_com = mem[imem_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] plain_word(input int a);
    logic [15:0] w;
    w = 16'hC000 | 16'(a & 16'h03FF);
    return w;
  endfunction

  task automatic push_exp(input logic [15:0] pc);
    exp_q.push_back({pc, mem[pc]});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_req       = 1'b0;
    dec_ready      = 1'b1;
    #2;
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_com", 32'(dec_com), 32'd0);
    chk("rst_dec_pc", 32'(dec_pc), 32'd0);
    chk("rst_dec_pc_plus1", 32'(dec_pc_plus1), 32'd0);
    chk("rst_fetch_count", 32'(fetch_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0000);
    exp_q.delete();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // scoreboard: every accepted IR transfer must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && dec_valid && dec_ready) begin
      if (exp_q.size() == 0)
        chk("sb_q_size", 32'd0, 32'd1);
      else
        chk("sb_pc_com", {dec_pc, dec_com}, exp_q.pop_front());
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 65536; i++) mem[i] = plain_word(i);

    // 1: sequential fetch, first valid two clocks after release
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(16'(i));
    next_cycle();
    chk("t1_boot_bubble", 32'(dec_valid), 32'd0);
    next_cycle();
    chk("t1_first_valid", 32'(dec_valid), 32'd1);
    chk("t1_first_pc", 32'(dec_pc), 32'd0);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      chk("t1_seq_pc", 32'(dec_pc), 32'(k));
    end
    chk("t1_fetch_count", 32'(fetch_count), 32'd4);
    chk("t1_sb_drain", 32'(exp_q.size()), 32'd0);

    // 2: J at 8 to 5, no bubble
    mem[8] = 16'h0805;
    do_reset();
    for (int i = 0; i < 9; i++) push_exp(16'(i));
    push_exp(16'd5);
    push_exp(16'd6);
    next_cycle();
    next_cycle();
    for (int k = 1; k < 9; k++) begin
      next_cycle();
      chk("t2_seq_pc", 32'(dec_pc), 32'(k));
    end
    chk("t2_j_word", 32'(dec_com), 32'h0805);
    next_cycle();
    chk("t2_target_valid", 32'(dec_valid), 32'd1);
    chk("t2_target_pc", 32'(dec_pc), 32'd5);
    next_cycle();
    chk("t2_after_target", 32'(dec_pc), 32'd6);
    next_cycle();
    chk("t2_pc7", 32'(dec_pc), 32'd7);
    chk("t2_fetch_count", 32'(fetch_count), 32'd12);
    chk("t2_sb_drain", 32'(exp_q.size()), 32'd0);
    mem[8] = plain_word(8);

    // 3: redirect while IR stalled
    do_reset();
    for (int i = 0; i < 5; i++) push_exp(16'(i));
    push_exp(16'd7);
    repeat (7) next_cycle();
    chk("t3_pre_pc", 32'(dec_pc), 32'd5);
    dec_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0007;
    next_cycle();
    chk("t3_flush_valid", 32'(dec_valid), 32'd0);
    chk("t3_flush_addr", 32'(imem_addr), 32'h0007);
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    next_cycle();
    chk("t3_target_valid", 32'(dec_valid), 32'd1);
    chk("t3_target_pc", 32'(dec_pc), 32'd7);
    chk("t3_fetch_count", 32'(fetch_count), 32'd7);
    next_cycle();
    chk("t3_sb_drain", 32'(exp_q.size()), 32'd0);

    // 4: decoder back-pressure for three clocks
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(16'(i));
    repeat (4) next_cycle();
    chk("t4_pre_pc", 32'(dec_pc), 32'd2);
    dec_ready = 1'b0;
    repeat (3) begin
      next_cycle();
      chk("t4_hold_valid", 32'(dec_valid), 32'd1);
      chk("t4_hold_pc", 32'(dec_pc), 32'd2);
      chk("t4_hold_com", 32'(dec_com), 32'(plain_word(2)));
      chk("t4_hold_addr", 32'(imem_addr), 32'd3);
      chk("t4_hold_count", 32'(fetch_count), 32'd3);
    end
    dec_ready = 1'b1;
    next_cycle();
    chk("t4_resume_pc", 32'(dec_pc), 32'd3);
    next_cycle();
    chk("t4_sb_drain", 32'(exp_q.size()), 32'd0);

    // 5: halt drains the IR, holds the PC, then resumes
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(16'(i));
    repeat (6) next_cycle();
    chk("t5_pre_pc", 32'(dec_pc), 32'd4);
    chk("t5_run_halted", 32'(halted), 32'd0);
    halt_req = 1'b1;
    next_cycle();
    chk("t5_drain_valid", 32'(dec_valid), 32'd0);
    chk("t5_halted", 32'(halted), 32'd1);
    chk("t5_addr", 32'(imem_addr), 32'd5);
    chk("t5_count", 32'(fetch_count), 32'd5);
    repeat (3) begin
      next_cycle();
      chk("t5_hold_halted", 32'(halted), 32'd1);
      chk("t5_hold_addr", 32'(imem_addr), 32'd5);
      chk("t5_hold_count", 32'(fetch_count), 32'd5);
    end
    halt_req = 1'b0;
    next_cycle();
    chk("t5_release_halted", 32'(halted), 32'd0);
    chk("t5_release_valid", 32'(dec_valid), 32'd0);
    next_cycle();
    chk("t5_resume_valid", 32'(dec_valid), 32'd1);
    chk("t5_resume_pc", 32'(dec_pc), 32'd5);
    next_cycle();
    chk("t5_sb_drain", 32'(exp_q.size()), 32'd0);

    // 6: PC wrap at FFFF, then asynchronous reset during a stall
    do_reset();
    push_exp(16'h0000);
    push_exp(16'hFFFF);
    repeat (2) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    next_cycle();
    chk("t6_flush_valid", 32'(dec_valid), 32'd0);
    chk("t6_addr_ffff", 32'(imem_addr), 32'hFFFF);
    redirect_valid = 1'b0;
    next_cycle();
    chk("t6_pc_ffff", 32'(dec_pc), 32'hFFFF);
    chk("t6_com_ffff", 32'(dec_com), 32'(plain_word(65535)));
    chk("t6_plus1_wrap", 32'(dec_pc_plus1), 32'h0000);
    next_cycle();
    chk("t6_pc_wrap", 32'(dec_pc), 32'h0000);
    chk("t6_plus1_after", 32'(dec_pc_plus1), 32'h0001);
    dec_ready = 1'b0;
    next_cycle();
    chk("t6_stall_valid", 32'(dec_valid), 32'd1);
    chk("t6_stall_addr", 32'(imem_addr), 32'h0001);
    chk("t6_sb_drain", 32'(exp_q.size()), 32'd0);
    #3;
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
